// File: rtl/lcd_value_formatter.sv
// Builds the 32-char "A=<val>" / "B=<val>" LCD frame from two binary values via double-dabble.
// Latency: 2*VAL_W+2 cycles from accepted start to UpdateLCD, plus one per busy cycle in PUBLISH.
// Backpressure: start honoured only while ready; publish waits while lcd_busy is high.
module lcd_value_formatter #(
   parameter int VAL_W  = 16,
   parameter int DIGITS = 5,
   parameter int LZB    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [VAL_W-1:0]      value_a,
   input  logic [VAL_W-1:0]      value_b,
   input  logic                  lcd_busy,
   output logic                  ready,
   output logic [31:0][7:0]      ASCII,
   output logic                  UpdateLCD
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(VAL_W + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONV_A,
      S_CONV_B,
      S_PUBLISH
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [BCD_W-1:0]     r_bcd;
   logic [BCD_W-1:0]     r_dig_a;
   logic [BCD_W-1:0]     r_dig_b;
   logic [BCD_W-1:0]     w_bcd_adj;
   logic [BCD_W-1:0]     w_bcd_nxt;
   logic [VAL_W-1:0]     r_shift;
   logic [VAL_W-1:0]     r_val_b;
   logic [CNT_W-1:0]     r_cnt;
   logic                 w_last;
   logic [31:0][7:0]     r_ascii;
   logic [31:0][7:0]     w_frame;
   logic                 r_update;
   logic [3:0]           w_nib_a;
   logic [3:0]           w_nib_b;
   logic                 w_seen_a;
   logic                 w_seen_b;

   assign ready     = (r_state == S_IDLE);
   assign ASCII     = r_ascii;
   assign UpdateLCD = r_update;
   assign w_last    = (r_cnt == CNT_W'(VAL_W - 1));

   // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int n = 0; n < DIGITS; n++) begin
         if (r_bcd[4*n +: 4] >= 4'd5) begin
            w_bcd_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
         end
      end
      w_bcd_nxt = {w_bcd_adj[BCD_W-2:0], r_shift[VAL_W-1]};
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: two conversions of VAL_W steps each, then wait for the LCD.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (start)     w_state_nxt = S_CONV_A;
         S_CONV_A:  if (w_last)    w_state_nxt = S_CONV_B;
         S_CONV_B:  if (w_last)    w_state_nxt = S_PUBLISH;
         S_PUBLISH: if (!lcd_busy) w_state_nxt = S_IDLE;
         default:                  w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: value capture, per-cycle BCD iteration, digit holding and frame publish.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bcd    <= '0;
         r_dig_a  <= '0;
         r_dig_b  <= '0;
         r_shift  <= '0;
         r_val_b  <= '0;
         r_cnt    <= '0;
         r_ascii  <= {32{8'h20}};
         r_update <= 1'b0;
      end else begin
         r_update <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_shift <= value_a;
                  r_val_b <= value_b;
                  r_bcd   <= '0;
                  r_cnt   <= '0;
               end
            end
            S_CONV_A: begin
               if (w_last) begin
                  // B is reloaded here so CONV_B starts from a clean BCD register.
                  r_dig_a <= w_bcd_nxt;
                  r_bcd   <= '0;
                  r_shift <= r_val_b;
                  r_cnt   <= '0;
               end else begin
                  r_bcd   <= w_bcd_nxt;
                  r_shift <= r_shift << 1;
                  r_cnt   <= r_cnt + CNT_W'(1);
               end
            end
            S_CONV_B: begin
               if (w_last) begin
                  r_dig_b <= w_bcd_nxt;
                  r_bcd   <= '0;
                  r_cnt   <= '0;
               end else begin
                  r_bcd   <= w_bcd_nxt;
                  r_shift <= r_shift << 1;
                  r_cnt   <= r_cnt + CNT_W'(1);
               end
            end
            S_PUBLISH: begin
               if (!lcd_busy) begin
                  r_ascii  <= w_frame;
                  r_update <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Frame assembly with optional leading-zero blanking; the units digit always shows.
   always_comb begin
      w_frame     = {32{8'h20}};
      w_frame[0]  = 8'h41;
      w_frame[1]  = 8'h3D;
      w_frame[16] = 8'h42;
      w_frame[17] = 8'h3D;
      w_seen_a    = (LZB == 0);
      w_seen_b    = (LZB == 0);
      w_nib_a     = '0;
      w_nib_b     = '0;
      for (int d = 0; d < DIGITS; d++) begin
         w_nib_a = r_dig_a[4*(DIGITS-1-d) +: 4];
         w_nib_b = r_dig_b[4*(DIGITS-1-d) +: 4];
         if (w_nib_a != 4'd0 || d == DIGITS - 1) w_seen_a = 1'b1;
         if (w_nib_b != 4'd0 || d == DIGITS - 1) w_seen_b = 1'b1;
         w_frame[2+d]  = w_seen_a ? {4'h3, w_nib_a} : 8'h20;
         w_frame[18+d] = w_seen_b ? {4'h3, w_nib_b} : 8'h20;
      end
   end

endmodule

// File: tb/tb_lcd_value_formatter.sv
// Directed bench for lcd_value_formatter with blanking on (u_dut) and off (u_dut0).
// Latency: frames checked at the UpdateLCD cycle, counted from the accepting edge.
// Backpressure: lcd_busy and ignored-start scenarios covered.
module tb_lcd_value_formatter;

   logic              clk;
   logic              reset;
   logic              start;
   logic [15:0]       value_a;
   logic [15:0]       value_b;
   logic              lcd_busy;
   logic              ready1;
   logic              ready0;
   logic [31:0][7:0]  ascii1;
   logic [31:0][7:0]  ascii0;
   logic              upd1;
   logic              upd0;

   int checks;
   int errors;

   lcd_value_formatter #(.VAL_W(16), .DIGITS(5), .LZB(1)) u_dut (
      .clk(clk), .reset(reset), .start(start), .value_a(value_a), .value_b(value_b),
      .lcd_busy(lcd_busy), .ready(ready1), .ASCII(ascii1), .UpdateLCD(upd1)
   );

   lcd_value_formatter #(.VAL_W(16), .DIGITS(5), .LZB(0)) u_dut0 (
      .clk(clk), .reset(reset), .start(start), .value_a(value_a), .value_b(value_b),
      .lcd_busy(lcd_busy), .ready(ready0), .ASCII(ascii0), .UpdateLCD(upd0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected frame from two 7-character line prefixes, rest padded with spaces.
   function automatic logic [31:0][7:0] mk_frame(input logic [55:0] l1, input logic [55:0] l2);
      logic [31:0][7:0] f;
      f = {32{8'h20}};
      for (int i = 0; i < 7; i++) begin
         f[i]    = l1[55-8*i -: 8];
         f[16+i] = l2[55-8*i -: 8];
      end
      return f;
   endfunction

   // Called in cycle T with start already high; returns cycles until UpdateLCD (200 = timeout).
   task automatic wait_pulse(output int n, output int rdy_early);
      n = 0;
      rdy_early = 0;
      do begin
         @(posedge clk); #1;
         start = 1'b0;
         n++;
         if (upd1 !== 1'b1 && ready1 !== 1'b0) rdy_early++;
      end while (upd1 !== 1'b1 && n < 200);
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; lcd_busy = 1'b0; value_a = '0; value_b = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if (ascii1 !== {32{8'h20}}) begin
         errors++; $display("FAIL reset_ascii got %h want all 20", ascii1);
      end
      checks++;
      if (upd1 !== 1'b0 || upd0 !== 1'b0) begin
         errors++; $display("FAIL reset_update got %b/%b want 0", upd1, upd0);
      end
      checks++;
      if (ready1 !== 1'b1 || ready0 !== 1'b1) begin
         errors++; $display("FAIL reset_ready got %b/%b want 1", ready1, ready0);
      end
   endtask

   task automatic test_zero();
      int n;
      int re;
      value_a = 16'd0; value_b = 16'd0; start = 1'b1;
      wait_pulse(n, re);
      checks++;
      if (n !== 34) begin
         errors++; $display("FAIL zero_latency got %0d want 34", n);
      end
      checks++;
      if (re !== 0) begin
         errors++; $display("FAIL zero_ready_busy got %0d early-ready cycles want 0", re);
      end
      checks++;
      if (ready1 !== 1'b1) begin
         errors++; $display("FAIL zero_ready_at_pulse got %b want 1", ready1);
      end
      checks++;
      if (ascii1 !== mk_frame("A=    0", "B=    0")) begin
         errors++; $display("FAIL zero_frame got %h want %h", ascii1, mk_frame("A=    0", "B=    0"));
      end
      checks++;
      if (ascii0 !== mk_frame("A=00000", "B=00000")) begin
         errors++; $display("FAIL zero_frame_nolzb got %h want %h", ascii0, mk_frame("A=00000", "B=00000"));
      end
      @(posedge clk); #1;
      checks++;
      if (upd1 !== 1'b0) begin
         errors++; $display("FAIL zero_single_pulse got %b want 0", upd1);
      end
   endtask

   task automatic test_max();
      int n;
      int re;
      value_a = 16'd65535; value_b = 16'd12345; start = 1'b1;
      wait_pulse(n, re);
      checks++;
      if (n !== 34) begin
         errors++; $display("FAIL max_latency got %0d want 34", n);
      end
      checks++;
      if (ascii1 !== mk_frame("A=65535", "B=12345")) begin
         errors++; $display("FAIL max_frame got %h want %h", ascii1, mk_frame("A=65535", "B=12345"));
      end
      checks++;
      if (ascii1[2] !== 8'h36 || ascii1[22] !== 8'h35 || ascii1[7] !== 8'h20) begin
         errors++; $display("FAIL max_bytes got %h %h %h want 36 35 20", ascii1[2], ascii1[22], ascii1[7]);
      end
   endtask

   task automatic test_nolzb();
      int n;
      int re;
      value_a = 16'd7; value_b = 16'd300; start = 1'b1;
      wait_pulse(n, re);
      checks++;
      if (n !== 34 || upd0 !== 1'b1) begin
         errors++; $display("FAIL nolzb_latency got %0d/%b want 34/1", n, upd0);
      end
      checks++;
      if (ascii0 !== mk_frame("A=00007", "B=00300")) begin
         errors++; $display("FAIL nolzb_frame got %h want %h", ascii0, mk_frame("A=00007", "B=00300"));
      end
      checks++;
      if (ascii1 !== mk_frame("A=    7", "B=  300")) begin
         errors++; $display("FAIL lzb_frame got %h want %h", ascii1, mk_frame("A=    7", "B=  300"));
      end
   endtask

   task automatic test_busy();
      int n;
      n = 0;
      value_a = 16'd1234; value_b = 16'd56789; start = 1'b1; lcd_busy = 1'b1;
      do begin
         @(posedge clk); #1;
         start = 1'b0;
         n++;
         if (n == 43) begin
            checks++;
            if (ascii1 !== mk_frame("A=    7", "B=  300")) begin
               errors++; $display("FAIL busy_hold_frame got %h want %h", ascii1, mk_frame("A=    7", "B=  300"));
            end
            lcd_busy = 1'b0;
         end
      end while (upd1 !== 1'b1 && n < 200);
      lcd_busy = 1'b0;
      checks++;
      if (n !== 44) begin
         errors++; $display("FAIL busy_latency got %0d want 44", n);
      end
      checks++;
      if (ascii1 !== mk_frame("A= 1234", "B=56789")) begin
         errors++; $display("FAIL busy_frame got %h want %h", ascii1, mk_frame("A= 1234", "B=56789"));
      end
   endtask

   task automatic test_back_to_back();
      int n;
      int re;
      n = 0;
      value_a = 16'd111; value_b = 16'd222; start = 1'b1;
      do begin
         @(posedge clk); #1;
         start = 1'b0;
         n++;
         if (n == 5) begin
            start = 1'b1; value_a = 16'd999; value_b = 16'd888;
         end
         if (n == 7) value_a = 16'd4321;
      end while (upd1 !== 1'b1 && n < 200);
      checks++;
      if (n !== 34) begin
         errors++; $display("FAIL ignore_latency got %0d want 34", n);
      end
      checks++;
      if (ascii1 !== mk_frame("A=  111", "B=  222")) begin
         errors++; $display("FAIL ignore_frame got %h want %h", ascii1, mk_frame("A=  111", "B=  222"));
      end
      // Start raised in the pulse cycle must be taken.
      value_a = 16'd42; value_b = 16'd7; start = 1'b1;
      wait_pulse(n, re);
      checks++;
      if (n !== 34) begin
         errors++; $display("FAIL b2b_latency got %0d want 34", n);
      end
      checks++;
      if (ascii0 !== mk_frame("A=00042", "B=00007")) begin
         errors++; $display("FAIL b2b_frame got %h want %h", ascii0, mk_frame("A=00042", "B=00007"));
      end
   endtask

   task automatic test_reset_abort();
      int pulses;
      pulses = 0;
      value_a = 16'd5; value_b = 16'd6; start = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (upd1 === 1'b1) pulses++;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if (ascii1 !== {32{8'h20}} || ascii0 !== {32{8'h20}}) begin
         errors++; $display("FAIL abort_ascii got %h want all 20", ascii1);
      end
      checks++;
      if (ready1 !== 1'b1 || upd1 !== 1'b0) begin
         errors++; $display("FAIL abort_ctrl got ready=%b upd=%b want 1/0", ready1, upd1);
      end
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (upd1 === 1'b1 || upd0 === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         errors++; $display("FAIL abort_no_pulse got %0d pulses want 0", pulses);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1; start = 1'b0; lcd_busy = 1'b0; value_a = '0; value_b = '0;
      @(posedge clk); #1;
      test_reset();
      test_zero();
      test_max();
      test_nolzb();
      test_busy();
      test_back_to_back();
      test_reset_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
